// File: rtl/pad_poller.sv
// Serial game-pad poller: drives a shared latch/pulse pair, shifts NUM_BITS active-low
// bits from each of NUM_PADS data lines and publishes all pads together once per frame.
module pad_poller #(
    parameter int NUM_PADS     = 2,
    parameter int NUM_BITS     = 8,
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int GAP_CYCLES   = 800000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_PADS-1:0]          data,
    output logic                         latch,
    output logic                         pulse,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic                         frame_valid
);

    localparam int MAX_LH  = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int MAX_CYC = (MAX_LH > GAP_CYCLES) ? MAX_LH : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int IW      = $clog2(NUM_BITS);

    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_BIT   = IW'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        PULSE,
        DONE,
        GAP
    } state_t;

    state_t                             state, state_next;
    logic [CW-1:0]                      count, count_next;
    logic [IW-1:0]                      index, index_next;
    logic [NUM_PADS-1:0]                sync1, sync2;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  shift;
    logic                               sample;
    logic                               publish;
    logic                               last;

    assign last = (count == '0);

    always_comb begin
        state_next = state;
        count_next = count;
        index_next = index;
        sample     = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = LATCH;
                    count_next = LATCH_LOAD;
                end
            end
            LATCH: begin
                if (last) begin
                    state_next = LOW;
                    count_next = HALF_LOAD;
                    index_next = '0;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            LOW: begin
                if (last) begin
                    sample     = 1'b1;
                    count_next = HALF_LOAD;
                    state_next = (index == LAST_BIT) ? DONE : PULSE;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            PULSE: begin
                if (last) begin
                    state_next = LOW;
                    count_next = HALF_LOAD;
                    index_next = index + 1'b1;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            DONE: begin
                publish    = 1'b1;
                state_next = GAP;
                count_next = GAP_LOAD;
            end
            GAP: begin
                if (last) begin
                    state_next = enable ? LATCH : IDLE;
                    count_next = enable ? LATCH_LOAD : '0;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // latch/pulse are registered from the next state so they line up exactly with the state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            index       <= '0;
            sync1       <= '0;
            sync2       <= '0;
            shift       <= '0;
            latch       <= 1'b0;
            pulse       <= 1'b0;
            buttons     <= '0;
            pressed     <= '0;
            frame_valid <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            index <= index_next;
            sync1 <= data;
            sync2 <= sync1;
            latch <= (state_next == LATCH);
            pulse <= (state_next == PULSE);
            if (sample) begin
                for (int unsigned p = 0; p < NUM_PADS; p++) begin
                    shift[p][index] <= ~sync2[p];
                end
            end
            frame_valid <= publish;
            if (publish) begin
                buttons <= shift;
                pressed <= shift & ~buttons;
            end else begin
                pressed <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pad_poller.sv
// Directed bench for pad_poller: frame-position model checked every cycle plus
// literal expectations for timing, patterns, press edges, enable drop, reset and sync delay.
module tb_pad_poller;

    localparam int NP        = 2;
    localparam int NB        = 8;
    localparam int LC        = 4;
    localparam int HC        = 2;
    localparam int GC        = 3;
    localparam int SHIFT_END = LC + (2*NB - 1)*HC;   // first cycle after the last LOW
    localparam int FRAME     = SHIFT_END + 1 + GC;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [NP-1:0]     data = '1;
    logic              latch, pulse, frame_valid;
    logic [NP*NB-1:0]  buttons, pressed;

    pad_poller #(
        .NUM_PADS(NP),
        .NUM_BITS(NB),
        .LATCH_CYCLES(LC),
        .HALF_CYCLES(HC),
        .GAP_CYCLES(GC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .data(data),
        .latch(latch),
        .pulse(pulse),
        .buttons(buttons),
        .pressed(pressed),
        .frame_valid(frame_valid)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // model state: frame start cycle, idle flag, data history at the last three edges
    bit            idle = 1'b1;
    int            fstart = 0;
    logic [15:0]   m_shift = '0, m_buttons = '0, m_pressed = '0;
    logic [NP-1:0] dq0 = '0, dq1 = '0, dq2 = '0;

    // stimulus: active-low line values per pad/bit, optional forced-low window on pad0
    logic [15:0] pat = '1;
    int          f0_lo = -10, f0_hi = -10;

    // observation counters
    int  latch_hi = 0, pulse_rise = 0, latch_fall_at = 0, latch_rise_at = 0, fv_at = 0;
    logic prev_latch = 1'b0, prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        idle = 1'b1;
        m_shift = '0;
        m_buttons = '0;
        m_pressed = '0;
        dq0 = '0; dq1 = '0; dq2 = '0;
    endtask

    task automatic model_step();
        int pp;
        if (!reset) begin
            model_reset();
            return;
        end
        dq2 = dq1; dq1 = dq0; dq0 = data;
        if (idle) begin
            if (enable) begin
                idle = 1'b0;
                fstart = cyc;
            end
        end else begin
            pp = cyc - 1 - fstart;
            if (pp >= LC && pp < SHIFT_END && (pp - LC) % (2*HC) == HC - 1)
                for (int p = 0; p < NP; p++) m_shift[p*NB + (pp - LC)/(2*HC)] = ~dq2[p];
            if (pp == SHIFT_END) begin
                m_pressed = m_shift & ~m_buttons;
                m_buttons = m_shift;
            end
            if (pp == FRAME - 1) begin
                if (enable) fstart = cyc;
                else idle = 1'b1;
            end
        end
    endtask

    task automatic compare();
        int pos;
        bit e_latch, e_pulse, e_fv;
        pos = cyc - fstart;
        e_latch = !idle && pos < LC;
        e_pulse = !idle && pos >= LC && pos < SHIFT_END && ((pos - LC) % (2*HC)) >= HC;
        e_fv    = !idle && pos == SHIFT_END + 1;
        check("latch", latch, e_latch);
        check("pulse", pulse, e_pulse);
        check("frame_valid", frame_valid, e_fv);
        check("buttons", buttons, m_buttons);
        check("pressed", pressed, e_fv ? m_pressed : 16'h0);
    endtask

    task automatic drive_data();
        int q;
        q = cyc - fstart;
        if (!idle && reset && q >= 0 && q < 4*NB) begin
            for (int p = 0; p < NP; p++) begin
                data[p] = pat[p*NB + q/4];
                if (p == 0 && q >= f0_lo && q <= f0_hi) data[p] = 1'b0;
            end
        end else begin
            data = '1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        model_step();
        compare();
        if (latch) latch_hi++;
        if (pulse && !prev_pulse) pulse_rise++;
        if (!latch && prev_latch) latch_fall_at = cyc;
        if (latch && !prev_latch) latch_rise_at = cyc;
        if (frame_valid) fv_at = cyc;
        prev_latch = latch;
        prev_pulse = pulse;
        drive_data();
    endtask

    task automatic wait_fv();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_valid && n < 3*FRAME);
        check("fv_seen", frame_valid, 1'b1);
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(!idle && cyc - fstart == target) && n < 3*FRAME);
        check("pulse_at_pos", pulse, 1'b1);
    endtask

    initial begin
        int n;
        int fv_n, latch_after;
        repeat (3) tick();
        check("rst_latch", latch, 1'b0);
        check("rst_buttons", buttons, 16'h0);
        check("rst_pressed", pressed, 16'h0);
        check("rst_fv", frame_valid, 1'b0);

        // timing frame, lines held high
        reset = 1'b1;
        enable = 1'b1;
        latch_hi = 0;
        pulse_rise = 0;
        wait_fv();
        check("latch_width", 32'(latch_hi), 32'd4);
        check("pulse_count", 32'(pulse_rise), 32'd7);
        check("fv_after_latch_fall", 32'(fv_at - latch_fall_at), 32'd31);
        check("idle_buttons", buttons, 16'h0);
        check("idle_pressed", pressed, 16'h0);
        pat = 16'h007E;
        n = 0;
        do begin tick(); n++; end while (!latch && n < 10);
        check("gap_to_latch", 32'(latch_rise_at - fv_at), 32'd3);

        // pattern: first frame presses, identical second frame does not
        wait_fv();
        check("pat_buttons1", buttons, 16'hFF81);
        check("pat_pressed1", pressed, 16'hFF81);
        wait_fv();
        check("pat_buttons2", buttons, 16'hFF81);
        check("pat_pressed2", pressed, 16'h0000);

        // press edge
        pat = 16'hFFF7;
        wait_fv();
        pat = 16'hFFD7;
        wait_fv();
        check("edge_buttons", buttons[7:0], 8'h28);
        check("edge_pressed", pressed[7:0], 8'h20);

        // synchroniser: change 1 cycle before bit2's sample point, then 3 cycles before
        pat = 16'hFFFF;
        f0_lo = 13; f0_hi = 13;
        wait_fv();
        check("sync_late", buttons[7:0], 8'h00);
        f0_lo = 11; f0_hi = 13;
        wait_fv();
        check("sync_early", buttons[7:0], 8'h04);
        check("sync_early_pressed", pressed[7:0], 8'h04);
        f0_lo = -10; f0_hi = -10;

        // enable drop during the 4th pulse
        pat = 16'h007E;
        wait_pos(LC + 3*2*HC + HC);
        enable = 1'b0;
        fv_n = 0;
        latch_after = 0;
        repeat (30) begin
            tick();
            if (frame_valid) fv_n++;
            if (fv_n > 0 && latch) latch_after++;
        end
        check("drop_fv_count", 32'(fv_n), 32'd1);
        check("drop_latch_after", 32'(latch_after), 32'd0);
        check("drop_buttons", buttons, 16'hFF81);
        enable = 1'b1;
        tick();
        check("reenable_latch", latch, 1'b1);

        // async reset during the 3rd pulse
        wait_pos(LC + 2*2*HC + HC);
        #3;
        reset = 1'b0;
        #1;
        check("arst_latch", latch, 1'b0);
        check("arst_pulse", pulse, 1'b0);
        check("arst_buttons", buttons, 16'h0);
        check("arst_pressed", pressed, 16'h0);
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        latch_hi = 0;
        wait_fv();
        check("arst_latch_width", 32'(latch_hi), 32'd4);
        check("arst_fresh_buttons", buttons, 16'hFF81);
        check("arst_fresh_pressed", pressed, 16'hFF81);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
